// File: rtl/rom_rect_blitter_if.sv
// rom_rect_blitter_if: blit command, ROM read port and framebuffer write port
interface rom_rect_blitter_if #(
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W = 17
);
  logic start;
  logic [ADDR_W-1:0] src_base;
  logic [X_W-1:0] src_w;
  logic [Y_W-1:0] src_h;
  logic [X_W-1:0] dst_x;
  logic [Y_W-1:0] dst_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [COLOUR_W-1:0] rom_q;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [COLOUR_W-1:0] colour;
  logic plot;
  logic busy;
  logic done;
  modport master (
    output start, src_base, src_w, src_h, dst_x, dst_y, rom_q,
    input rom_addr, x, y, colour, plot, busy, done
  );
  modport slave (
    input start, src_base, src_w, src_h, dst_x, dst_y, rom_q,
    output rom_addr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/rom_rect_blitter.sv
// rom_rect_blitter: copies a rectangle from ROM to the framebuffer, with clipping and optional colour key
module rom_rect_blitter #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W = 17,
  parameter int ROM_LAT = 1,
  parameter int TRANSPARENT_EN = 0,
  parameter int TRANSPARENT_KEY = 0
) (
  input logic CLOCK_50,
  input logic resetn,
  rom_rect_blitter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [X_W:0] SW = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] SH = SCREEN_H[Y_W:0];
  localparam logic [COLOUR_W-1:0] KEY = TRANSPARENT_KEY[COLOUR_W-1:0];
  state_t state;
  logic [X_W-1:0] w_r, dx_r, col, x_hold;
  logic [Y_W-1:0] h_r, dy_r, row, y_hold;
  logic [COLOUR_W-1:0] c_hold;
  logic [ROM_LAT-1:0] v, v_next;
  logic [X_W:0] px [ROM_LAT];
  logic [Y_W:0] py [ROM_LAT];
  logic issue, last, col_end, zero, out_v, clip, key;
  assign issue = state == RUN;
  assign col_end = col == w_r - X_W'(1);
  assign last = col_end && row == h_r - Y_W'(1);
  assign zero = bus.src_w == '0 || bus.src_h == '0;
  assign v_next = ROM_LAT'({v, issue});
  assign out_v = v[ROM_LAT-1];
  assign clip = px[ROM_LAT-1] >= SW || py[ROM_LAT-1] >= SH;
  assign key = TRANSPARENT_EN != 0 && bus.rom_q == KEY;
  assign bus.plot = out_v && !clip && !key;
  assign bus.x = out_v ? px[ROM_LAT-1][X_W-1:0] : x_hold;
  assign bus.y = out_v ? py[ROM_LAT-1][Y_W-1:0] : y_hold;
  assign bus.colour = out_v ? bus.rom_q : c_hold;
  // control FSM: latch the command, walk the source row-major, wait for the ROM pipeline to empty
  always_ff @(posedge CLOCK_50)
    if (!resetn) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.rom_addr <= '0;
    end else
      case (state)
        IDLE: if (bus.start) begin
          w_r <= bus.src_w;
          h_r <= bus.src_h;
          dx_r <= bus.dst_x;
          dy_r <= bus.dst_y;
          col <= '0;
          row <= '0;
          if (!zero) bus.rom_addr <= bus.src_base;
          state <= zero ? DONE : RUN;
          bus.busy <= !zero;
          bus.done <= zero;
        end
        RUN: if (last) state <= DRAIN;
        else begin
          bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
          col <= col_end ? '0 : col + X_W'(1);
          row <= col_end ? row + Y_W'(1) : row;
        end
        DRAIN: if (v_next == '0) begin
          state <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          bus.done <= 1'b0;
        end
      endcase
  // pixel pipeline matching the ROM latency, plus hold registers for the idle output value
  always_ff @(posedge CLOCK_50) begin
    v <= resetn ? v_next : '0;
    px[0] <= {1'b0, dx_r} + {1'b0, col};
    py[0] <= {1'b0, dy_r} + {1'b0, row};
    for (int i = 1; i < ROM_LAT; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
    if (!resetn) begin
      x_hold <= '0;
      y_hold <= '0;
      c_hold <= '0;
    end else if (out_v) begin
      x_hold <= bus.x;
      y_hold <= bus.y;
      c_hold <= bus.colour;
    end
  end
endmodule

// File: tb/tb_rom_rect_blitter.sv
// tb_rom_rect_blitter: scoreboard bench for two blitter configurations (latency 1, and latency 3 with colour key 0)
module tb_rom_rect_blitter;
  typedef struct {int cyc; int x; int y; int c; int a;} pix_t;
  logic clk = 0;
  logic resetn = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  pix_t qa_exp[$];
  pix_t qb_exp[$];
  logic [2:0] qa;
  logic [2:0] qb [3];
  rom_rect_blitter_if ifa();
  rom_rect_blitter_if ifb();
  rom_rect_blitter #(.ROM_LAT(1)) dut_a (.CLOCK_50(clk), .resetn(resetn), .bus(ifa));
  rom_rect_blitter #(.ROM_LAT(3), .TRANSPARENT_EN(1), .TRANSPARENT_KEY(0)) dut_b (.CLOCK_50(clk), .resetn(resetn), .bus(ifb));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [2:0] rom(input int a);
    return 3'(a * 5);
  endfunction
  always @(posedge clk) begin
    qa <= rom(int'(ifa.rom_addr));
    qb[0] <= rom(int'(ifb.rom_addr));
    qb[1] <= qb[0];
    qb[2] <= qb[1];
  end
  assign ifa.rom_q = qa;
  assign ifb.rom_q = qb[2];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ifa.plot) begin
      if (qa_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_plot at cycle %0d: x=%0d y=%0d", cyc, ifa.x, ifa.y);
      end else begin
        pix_t e;
        e = qa_exp.pop_front();
        chk("a_plot_cycle", cyc, e.cyc);
        chk("a_x", int'(ifa.x), e.x);
        chk("a_y", int'(ifa.y), e.y);
        chk("a_colour", int'(ifa.colour), e.c);
        chk("a_rom_addr", int'(ifa.rom_addr), e.a);
      end
    end
    if (ifb.plot) begin
      if (qb_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_plot at cycle %0d: x=%0d y=%0d", cyc, ifb.x, ifb.y);
      end else begin
        pix_t e;
        e = qb_exp.pop_front();
        chk("b_plot_cycle", cyc, e.cyc);
        chk("b_x", int'(ifb.x), e.x);
        chk("b_y", int'(ifb.y), e.y);
        chk("b_colour", int'(ifb.colour), e.c);
        chk("b_rom_addr", int'(ifb.rom_addr), e.a);
      end
    end
  end
  task automatic blit(input int inst, input int base, input int w, input int h, input int dx, input int dy, output int c0);
    int lat, n, idx;
    pix_t e;
    lat = inst ? 3 : 1;
    n = w * h;
    c0 = cyc;
    if (inst == 0) begin
      ifa.src_base = 17'(base); ifa.src_w = 9'(w); ifa.src_h = 8'(h);
      ifa.dst_x = 9'(dx); ifa.dst_y = 8'(dy); ifa.start = 1'b1;
    end else begin
      ifb.src_base = 17'(base); ifb.src_w = 9'(w); ifb.src_h = 8'(h);
      ifb.dst_x = 9'(dx); ifb.dst_y = 8'(dy); ifb.start = 1'b1;
    end
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        idx = r * w + c;
        e.cyc = c0 + idx + 1 + lat;
        e.x = dx + c;
        e.y = dy + r;
        e.c = int'(rom(base + idx));
        e.a = (base + ((idx + lat < n - 1) ? idx + lat : n - 1)) % (1 << 17);
        if (e.x < 320 && e.y < 240 && !(inst == 1 && e.c == 0)) begin
          if (inst == 0) qa_exp.push_back(e);
          else qb_exp.push_back(e);
        end
      end
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask
  task automatic wait_done(input int inst, input int exp_cyc, input int budget);
    int t;
    for (t = 0; t < budget; t++) begin
      @(negedge clk);
      if (inst ? ifb.done : ifa.done) break;
    end
    if (t == budget) begin
      checks++;
      errors++;
      $display("FAIL done_timeout inst %0d: no done within %0d cycles, expected cycle %0d", inst, budget, exp_cyc);
    end else begin
      chk("done_cycle", cyc, exp_cyc);
      chk("busy_at_done", int'(inst ? ifb.busy : ifa.busy), 0);
      @(negedge clk);
      chk("done_one_cycle", int'(inst ? ifb.done : ifa.done), 0);
    end
  endtask
  initial begin
    int c0, a0;
    {ifa.start, ifa.src_base, ifa.src_w, ifa.src_h, ifa.dst_x, ifa.dst_y} = '0;
    {ifb.start, ifb.src_base, ifb.src_w, ifb.src_h, ifb.dst_x, ifb.dst_y} = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rom_addr", int'(ifa.rom_addr), 0);
    chk("rst_x", int'(ifa.x), 0);
    chk("rst_y", int'(ifa.y), 0);
    chk("rst_colour", int'(ifa.colour), 0);
    chk("rst_plot", int'(ifa.plot), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_done", int'(ifa.done), 0);
    chk("rst_b_plot", int'(ifb.plot), 0);
    chk("rst_b_busy", int'(ifb.busy), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    blit(0, 0, 320, 240, 0, 0, c0);
    @(negedge clk);
    chk("full_busy", int'(ifa.busy), 1);
    wait_done(0, c0 + 76802, 80000);
    @(posedge clk); #1;
    blit(0, 100, 4, 3, 318, 238, c0);
    wait_done(0, c0 + 14, 40);
    @(posedge clk); #1;
    a0 = int'(ifa.rom_addr);
    blit(0, 500, 0, 7, 3, 3, c0);
    @(negedge clk);
    chk("zero_done", int'(ifa.done), 1);
    chk("zero_done_cycle", cyc, c0 + 1);
    chk("zero_busy", int'(ifa.busy), 0);
    chk("zero_rom_addr", int'(ifa.rom_addr), a0);
    @(negedge clk);
    chk("zero_done_low", int'(ifa.done), 0);
    chk("zero_busy_low", int'(ifa.busy), 0);
    @(posedge clk); #1;
    blit(0, 0, 320, 240, 0, 0, c0);
    repeat (49) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    qa_exp.delete();
    @(negedge clk);
    chk("abort_plot", int'(ifa.plot), 0);
    chk("abort_busy", int'(ifa.busy), 0);
    chk("abort_done", int'(ifa.done), 0);
    chk("abort_rom_addr", int'(ifa.rom_addr), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    blit(0, 40, 2, 2, 1, 1, c0);
    wait_done(0, c0 + 6, 40);
    @(posedge clk); #1;
    blit(1, 8, 2, 1, 10, 20, c0);
    wait_done(1, c0 + 6, 40);
    @(posedge clk); #1;
    blit(1, 1, 2, 2, 5, 7, c0);
    ifb.src_base = 17'd200; ifb.src_w = 9'd3; ifb.src_h = 8'd3;
    ifb.dst_x = 9'd0; ifb.dst_y = 8'd0; ifb.start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    wait_done(1, c0 + 8, 40);
    repeat (6) @(posedge clk);
    #1;
    chk("a_leftover", qa_exp.size(), 0);
    chk("b_leftover", qb_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
